vcd_change_capture: RTL and testbench

//   Synthesizable value-change capture stage: samples a probe bus each clk, and while a dump

---
 rtl/vcd_change_capture.sv | 139 +++++++++++++
 tb/tb_vcd_change_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vcd_change_capture.sv
// vcd_change_capture
//   Value-change capture stage. The probe bus is sampled on every rising edge.
//   While the dump window is open, the stage emits {timestamp, value} records
//   only when the probe changes. It also emits one full snapshot on the first
//   edge after the window opens. Records pass through a small show-ahead FIFO
//   and are drained by a downstream trace writer over a valid/ready handshake.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   probe      in   observed bus, sampled every edge
//   dump_on    in   pulse: open window (ignored when already open)
//   dump_off   in   pulse: close window (wins over dump_on)
//   rec_valid  out  FIFO head holds a record
//   rec_ready  in   consumer takes head record this cycle
//   rec_time   out  timestamp of head record (0 when empty)
//   rec_data   out  probe value of head record (0 when empty)
//   capturing  out  window open
//   overflow   out  sticky: a record was dropped on a full FIFO
//   level      out  FIFO occupancy 0..DEPTH
module vcd_change_capture #(
  parameter int DW       = 8,
  parameter int TSW      = 16,
  parameter int DEPTH    = 8,
  parameter int START_ON = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              probe,
  input  logic                       dump_on,
  input  logic                       dump_off,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [TSW-1:0]             rec_time,
  output logic [DW-1:0]              rec_data,
  output logic                       capturing,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_OFF, S_SNAP, S_ON} state_t;

  state_t          r_state;
  logic [TSW-1:0]  r_ts;
  logic [DW-1:0]   r_last;
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [LW-1:0]   r_level;
  logic            r_overflow;
  logic [TSW-1:0]  r_rec_time;
  logic [DW-1:0]   r_rec_data;
  logic [TSW-1:0]  r_mem_time [DEPTH];
  logic [DW-1:0]   r_mem_data [DEPTH];

  logic            w_push_try;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic [AW-1:0]   w_rd_next;
  logic [LW-1:0]   w_level_next;
  logic [LW-1:0]   w_remain;

  // A push is attempted on a snapshot edge or a changed value while ON.
  // dump_off on the same edge suppresses it.
  assign w_push_try   = !dump_off &&
                        ((r_state == S_SNAP) ||
                         ((r_state == S_ON) && (probe != r_last)));
  assign w_pop        = (r_level != '0) && rec_ready;
  assign w_full       = (r_level == LW'(DEPTH));
  // A full FIFO still accepts a push when a slot frees up on the same edge.
  assign w_push       = w_push_try && (!w_full || w_pop);
  assign w_rd_next    = r_rd + AW'(w_pop);
  assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);
  // Entries that stay in the FIFO after this edge's pop. Zero means the
  // record being pushed becomes the new head.
  assign w_remain     = r_level - LW'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (START_ON != 0) ? S_SNAP : S_OFF;
      r_ts       <= '0;
      r_last     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_rec_time <= '0;
      r_rec_data <= '0;
    end else begin
      r_ts <= r_ts + TSW'(1);

      case (r_state)
        S_OFF:   if (dump_on && !dump_off) r_state <= S_SNAP;
        S_SNAP:  r_state <= dump_off ? S_OFF : S_ON;
        S_ON:    if (dump_off) r_state <= S_OFF;
        default: r_state <= S_OFF;
      endcase

      // last tracks every attempted push, so a dropped value is not re-emitted.
      if (w_push_try) r_last <= probe;
      if (w_push_try && !w_push) r_overflow <= 1'b1;

      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_next;
      r_level <= w_level_next;

      // The registered head follows the next occupant of the read slot.
      // An empty FIFO shows zeros.
      if (w_level_next == '0) begin
        r_rec_time <= '0;
        r_rec_data <= '0;
      end else if (w_remain == '0) begin
        r_rec_time <= r_ts;
        r_rec_data <= probe;
      end else begin
        r_rec_time <= r_mem_time[w_rd_next];
        r_rec_data <= r_mem_data[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_time[r_wr] <= r_ts;
      r_mem_data[r_wr] <= probe;
    end
  end

  assign rec_valid = (r_level != '0);
  assign rec_time  = r_rec_time;
  assign rec_data  = r_rec_data;
  assign capturing = (r_state != S_OFF);
  assign overflow  = r_overflow;
  assign level     = r_level;

endmodule

// File: tb/tb_vcd_change_capture.sv
// Directed bench for vcd_change_capture. Instance a uses the defaults
// (TSW=16, START_ON=1). Instance b uses TSW=4, START_ON=0 for the timestamp
// wrap and the asynchronous reset cases.
module tb_vcd_change_capture;

  logic        clk;
  logic        rst_a, rst_b;
  logic [7:0]  probe_a, probe_b;
  logic        on_a, off_a, on_b, off_b;
  logic        rdy_a, rdy_b;
  logic        vld_a, vld_b;
  logic [15:0] time_a;
  logic [3:0]  time_b;
  logic [7:0]  data_a, data_b;
  logic        cap_a, cap_b, ovf_a, ovf_b;
  logic [3:0]  lvl_a, lvl_b;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  vcd_change_capture #(.DW(8), .TSW(16), .DEPTH(8), .START_ON(1)) u_a (
    .clk(clk), .rst(rst_a), .probe(probe_a), .dump_on(on_a), .dump_off(off_a),
    .rec_valid(vld_a), .rec_ready(rdy_a), .rec_time(time_a), .rec_data(data_a),
    .capturing(cap_a), .overflow(ovf_a), .level(lvl_a));

  vcd_change_capture #(.DW(8), .TSW(4), .DEPTH(8), .START_ON(0)) u_b (
    .clk(clk), .rst(rst_b), .probe(probe_b), .dump_on(on_b), .dump_off(off_b),
    .rec_valid(vld_b), .rec_ready(rdy_b), .rec_time(time_b), .rec_data(data_b),
    .capturing(cap_b), .overflow(ovf_b), .level(lvl_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit; edge_n is the ts of the next edge.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    probe_a = 8'h00; probe_b = 8'h00;
    on_a = 0; off_a = 0; on_b = 0; off_b = 0;
    rdy_a = 0; rdy_b = 1;
    #1;
    chk("rst_valid", vld_a, 0);
    chk("rst_level", lvl_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_time", time_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_cap_a", cap_a, 1);
    chk("rst_cap_b", cap_b, 0);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // snapshot on first edge, then silence with probe held
    tick();                                   // edge 0
    chk("snap_valid", vld_a, 1);
    chk("snap_time", time_a, 0);
    chk("snap_data", data_a, 8'h00);
    chk("snap_level", lvl_a, 1);
    tick_to(21);
    chk("hold_level", lvl_a, 1);
    chk("hold_time", time_a, 0);
    rdy_a = 1;
    tick();                                   // edge 21 pops
    chk("pop_valid", vld_a, 0);
    chk("empty_data", data_a, 0);

    // two changes, each visible one edge after sampling
    tick_to(30);
    chk("pre_chg_valid", vld_a, 0);
    probe_a = 8'hA5;
    tick();                                   // edge 30
    chk("chg1_valid", vld_a, 1);
    chk("chg1_time", time_a, 30);
    chk("chg1_data", data_a, 8'hA5);
    tick();                                   // edge 31 pops
    chk("chg1_pop", vld_a, 0);
    probe_a = 8'h3C;
    tick();                                   // edge 32
    chk("chg2_time", time_a, 32);
    chk("chg2_data", data_a, 8'h3C);
    tick();
    chk("chg2_pop", vld_a, 0);

    // window close, toggling probe ignored, combined pulses stay off
    tick_to(40);
    probe_a = 8'h11; off_a = 1;
    tick();                                   // edge 40
    off_a = 0;
    chk("off_cap", cap_a, 0);
    chk("off_valid", vld_a, 0);
    while (edge_n < 50) begin
      probe_a = 8'(edge_n);
      tick();
    end
    chk("off_level", lvl_a, 0);
    on_a = 1; off_a = 1;
    tick();                                   // edge 50
    on_a = 0; off_a = 0;
    chk("both_cap", cap_a, 0);
    probe_a = 8'h5A;
    tick_to(55);
    chk("both_level", lvl_a, 0);
    on_a = 1;
    tick();                                   // edge 55 -> SNAP
    on_a = 0;
    chk("on_cap", cap_a, 1);
    chk("on_valid", vld_a, 0);
    rdy_a = 0;
    tick();                                   // edge 56 snapshot
    chk("resnap_time", time_a, 56);
    chk("resnap_data", data_a, 8'h5A);
    tick_to(61);
    chk("resnap_only", lvl_a, 1);
    rdy_a = 1;
    tick();                                   // edge 61 pops
    chk("resnap_pop", lvl_a, 0);

    // fill, then push and pop on the same full edge
    tick_to(70);
    rdy_a = 0;
    for (int i = 0; i < 8; i++) begin
      probe_a = 8'h20 + 8'(i);
      tick();                                 // edges 70..77
    end
    chk("full_level", lvl_a, 8);
    chk("full_ovf", ovf_a, 0);
    chk("full_head", time_a, 70);
    probe_a = 8'h28; rdy_a = 1;
    tick();                                   // edge 78
    chk("pp_level", lvl_a, 8);
    chk("pp_ovf", ovf_a, 0);
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain_time", time_a, 71 + i);
      chk("pp_drain_data", data_a, 32'h21 + i);
      tick();                                 // edges 79..86
    end
    chk("pp_empty", lvl_a, 0);

    // overflow: 10 changes into 8 slots, first 8 kept in order
    tick_to(90);
    rdy_a = 0;
    for (int i = 0; i < 10; i++) begin
      probe_a = 8'h30 + 8'(i);
      tick();                                 // edges 90..99
    end
    chk("ovf_level", lvl_a, 8);
    chk("ovf_flag", ovf_a, 1);
    rdy_a = 1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_time", time_a, 90 + i);
      chk("ovf_drain_data", data_a, 32'h30 + i);
      tick();                                 // edges 100..107
    end
    tick_to(112);
    chk("ovf_no_reemit", lvl_a, 0);
    chk("ovf_sticky", ovf_a, 1);

    // instance b: 4-bit timestamp wrap, then async reset mid-burst
    tick_to(124);
    on_b = 1;
    tick();                                   // edge 124, ts 12
    on_b = 0;
    chk("b_cap", cap_b, 1);
    tick();                                   // edge 125 snapshot, ts 13
    chk("b_snap_time", time_b, 13);
    chk("b_snap_data", data_b, 8'h00);
    tick();                                   // edge 126 pops
    chk("b_snap_pop", vld_b, 0);
    rdy_b = 0; probe_b = 8'h77;
    tick();                                   // edge 127, ts 15
    chk("b_t15_time", time_b, 15);
    chk("b_t15_data", data_b, 8'h77);
    probe_b = 8'h88;
    tick();                                   // edge 128, ts 0
    chk("b_wrap_level", lvl_b, 2);
    rdy_b = 1;
    tick();                                   // edge 129 pops
    chk("b_wrap_time", time_b, 0);
    chk("b_wrap_data", data_b, 8'h88);
    rdy_b = 0; probe_b = 8'h99;
    tick();
    probe_b = 8'hAA;
    tick();
    chk("b_burst_level", lvl_b, 3);
    #1 rst_b = 1'b1;
    #1;
    chk("b_arst_valid", vld_b, 0);
    chk("b_arst_level", lvl_b, 0);
    chk("b_arst_time", time_b, 0);
    chk("b_arst_cap", cap_b, 0);
    rst_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
